// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that feeds bytes from two requesters into one UART transmitter.
// Define UART_SCHED_CRLF_EN to follow every granted byte with 0x0D, 0x0A under the same grant.
module uart_tx_scheduler #(
   parameter int unsigned GAP_CYCLES  = 16,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic       grant_id,
   output logic       timeout_err
);

`ifdef UART_SCHED_CRLF_EN
   typedef enum logic [2:0] {
      StIdle, StStart, StWaitAck, StWaitDone, StGap, StSuffix
   } state_t;
`else
   typedef enum logic [2:0] {
      StIdle, StStart, StWaitAck, StWaitDone, StGap
   } state_t;
`endif

   localparam logic [7:0] AckLast = 8'(ACK_TIMEOUT - 1);
   localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);
   localparam state_t     AfterFrame = (GAP_CYCLES == 0) ? StIdle : StGap;

   state_t     state;
   logic [7:0] cnt;
   logic       last_grant;
   logic       pick1;
`ifdef UART_SCHED_CRLF_EN
   logic [1:0] sfx_cnt;
`endif

   // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
   always_comb begin
      pick1 = req1_valid && (!req0_valid || !last_grant);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         cnt         <= 8'd0;
         last_grant  <= 1'b1;
         req0_ready  <= 1'b0;
         req1_ready  <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         grant_id    <= 1'b0;
         timeout_err <= 1'b0;
`ifdef UART_SCHED_CRLF_EN
         sfx_cnt     <= 2'd0;
`endif
      end else begin
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         tx_start   <= 1'b0;
         case (state)
            StIdle: begin
               cnt <= 8'd0;
               if (req0_valid || req1_valid) begin
                  tx_data    <= pick1 ? req1_data : req0_data;
                  grant_id   <= pick1;
                  last_grant <= pick1;
                  req0_ready <= !pick1;
                  req1_ready <= pick1;
                  state      <= StStart;
`ifdef UART_SCHED_CRLF_EN
                  sfx_cnt    <= 2'd0;
`endif
               end
            end
            StStart: begin
               tx_start <= 1'b1;
               cnt      <= 8'd0;
               state    <= StWaitAck;
            end
            StWaitAck: begin
               if (tx_busy) begin
                  state <= StWaitDone;
               end else if (cnt >= AckLast) begin
                  // Byte is dropped; any pending suffix bytes are abandoned with it.
                  timeout_err <= 1'b1;
                  cnt         <= 8'd0;
                  state       <= AfterFrame;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            StWaitDone: begin
               cnt <= 8'd0;
               if (!tx_busy) begin
`ifdef UART_SCHED_CRLF_EN
                  state <= (sfx_cnt < 2'd2) ? StSuffix : AfterFrame;
`else
                  state <= AfterFrame;
`endif
               end
            end
            StGap: begin
               // Compare stops the count at GapLast, so it never wraps.
               if (cnt >= GapLast) begin
                  cnt   <= 8'd0;
                  state <= StIdle;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
`ifdef UART_SCHED_CRLF_EN
            StSuffix: begin
               tx_data <= (sfx_cnt == 2'd0) ? 8'h0D : 8'h0A;
               sfx_cnt <= sfx_cnt + 2'd1;
               state   <= StStart;
            end
`endif
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: vector table plus sequences for gap, timeout and reset.
// Also covers the UART_SCHED_CRLF_EN build when that macro is defined.
module tb_uart_tx_scheduler;

   localparam int Gap = 16;
`ifdef UART_SCHED_CRLF_EN
   localparam int NumBytes = 3;
`else
   localparam int NumBytes = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0, tx_busy = 1'b0;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic       req0_ready, req1_ready, tx_start, grant_id, timeout_err;
   logic [7:0] tx_data;

   // Second instance with no inter-frame gap.
   logic       s_req0_valid = 1'b0, s_req1_valid = 1'b0, s_busy = 1'b0;
   logic [7:0] s_req0_data = 8'h00, s_req1_data = 8'h00;
   logic       s_ready0, s_ready1, s_tx_start, s_grant, s_err;
   logic [7:0] s_tx_data;

   int errors = 0;
   int checks = 0;
   int ready_cnt = 0;
   int start_cnt = 0;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.GAP_CYCLES(Gap), .ACK_TIMEOUT(15)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant_id(grant_id), .timeout_err(timeout_err)
   );

   uart_tx_scheduler #(.GAP_CYCLES(0), .ACK_TIMEOUT(15)) u_dut_nogap (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(s_req0_valid), .req0_data(s_req0_data), .req0_ready(s_ready0),
      .req1_valid(s_req1_valid), .req1_data(s_req1_data), .req1_ready(s_ready1),
      .tx_start(s_tx_start), .tx_data(s_tx_data), .tx_busy(s_busy),
      .grant_id(s_grant), .timeout_err(s_err)
   );

   always @(negedge clk) begin
      if (req0_ready) ready_cnt++;
      if (req1_ready) ready_cnt++;
      if (tx_start) start_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish within 500000 time units");
      $fatal(1);
   end

   typedef struct {
      logic       r0v;
      logic [7:0] r0d;
      logic       r1v;
      logic [7:0] r1d;
      logic       exp_any;
      logic       exp_gid;
      logic [7:0] exp_data;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] cur_start(input bit sel);
      return 32'(sel ? s_tx_start : tx_start);
   endfunction

   function automatic logic [31:0] cur_data(input bit sel);
      return 32'(sel ? s_tx_data : tx_data);
   endfunction

   function automatic logic [31:0] cur_gid(input bit sel);
      return 32'(sel ? s_grant : grant_id);
   endfunction

   task automatic set_busy(input bit sel, input logic v);
      if (sel) s_busy = v;
      else tx_busy = v;
   endtask

   task automatic wait_ready(input bit sel, input int max, output int n, output bit got);
      n = 0;
      got = 1'b0;
      while (!got && n < max) begin
         @(posedge clk);
         #1;
         n++;
         got = sel ? (s_ready0 | s_ready1) : (req0_ready | req1_ready);
      end
   endtask

   // Transmitter model: busy rises 2 cycles after tx_start and stays up busy_len cycles.
   // Returns right after busy is dropped for the last byte of the grant.
   task automatic serve(input bit sel, input logic gid, input logic [7:0] data,
                        input int busy_len);
      logic [7:0] exp_b;
      int n;
      for (int b = 0; b < NumBytes; b++) begin
         exp_b = (b == 0) ? data : ((b == 1) ? 8'h0D : 8'h0A);
         n = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
         end while (cur_start(sel) == 0 && n < 6);
         check("tx_start_latency", 32'(n), (b == 0) ? 32'd1 : 32'd3);
         check("tx_data_at_start", cur_data(sel), 32'(exp_b));
         check("grant_id_at_start", cur_gid(sel), 32'(gid));
         @(posedge clk);
         #1;
         check("tx_start_single_pulse", cur_start(sel), 32'd0);
         @(posedge clk);
         #1;
         set_busy(sel, 1'b1);
         repeat (busy_len) begin
            @(posedge clk);
            #1;
         end
         check("tx_data_hold", cur_data(sel), 32'(exp_b));
         set_busy(sel, 1'b0);
      end
   endtask

   task automatic idle_wait(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vec_t vecs[7];
      int   n, rc, sc;
      bit   got;
      logic [7:0] tie_exp[4];

      vecs[0] = '{1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1, 1'b0, 8'hA1};
      vecs[1] = '{1'b1, 8'hC3, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC3};
      vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b1, 8'h99};
      vecs[3] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 8'h11};
      vecs[4] = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 1'b1, 8'h44};
      vecs[5] = '{1'b0, 8'h77, 1'b0, 8'h88, 1'b0, 1'b0, 8'h00};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A};
      tie_exp[0] = 8'h11;
      tie_exp[1] = 8'h22;
      tie_exp[2] = 8'h11;
      tie_exp[3] = 8'h22;

      // Reset values, with inputs active to show they are ignored.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      tx_busy    = 1'b1;
      idle_wait(3);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_req1_ready", 32'(req1_ready), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tx_busy    = 1'b0;
      rst_n      = 1'b1;
      idle_wait(2);

      // Continuous tie: alternating grants starting with requester 0.
      rc = ready_cnt;
      req0_valid = 1'b1;
      req0_data  = 8'h11;
      req1_valid = 1'b1;
      req1_data  = 8'h22;
      for (int k = 0; k < 4; k++) begin
         wait_ready(1'b0, 40, n, got);
         check("tie_grant_seen", 32'(got), 32'd1);
         check("tie_ready_onehot", 32'(req0_ready ^ req1_ready), 32'd1);
         check("tie_ready1", 32'(req1_ready), 32'(k % 2));
         check("tie_data", 32'(tx_data), 32'(tie_exp[k]));
         serve(1'b0, 1'(k % 2), tie_exp[k], 3);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      idle_wait(Gap + 4);
      check("tie_ready_pulses", 32'(ready_cnt - rc), 32'd4);

      // Single request, 100-cycle frame, then gap length measured via the next grant.
      req0_valid = 1'b1;
      req0_data  = 8'h41;
      wait_ready(1'b0, 5, n, got);
      check("single_ready_latency", 32'(n), 32'd1);
      check("single_ready0", 32'(req0_ready), 32'd1);
      check("single_grant_id", 32'(grant_id), 32'd0);
      req0_valid = 1'b0;
      serve(1'b0, 1'b0, 8'h41, 100);
      req0_valid = 1'b1;
      req0_data  = 8'h42;
      wait_ready(1'b0, 40, n, got);
      // 16 gap cycles, one edge to enter GAP and one to grant from IDLE.
      check("gap_then_grant", 32'(n), 32'(Gap + 2));
      req0_valid = 1'b0;
      serve(1'b0, 1'b0, 8'h42, 3);
      idle_wait(Gap + 4);

      // Timeout: transmitter never acknowledges.
      rc = ready_cnt;
      req0_valid = 1'b1;
      req0_data  = 8'h77;
      wait_ready(1'b0, 5, n, got);
      req0_valid = 1'b0;
      @(posedge clk);
      #1;
      check("to_tx_start", 32'(tx_start), 32'd1);
      check("to_err_before", 32'(timeout_err), 32'd0);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!timeout_err && n < 40);
      check("to_err_cycles", 32'(n), 32'd15);
      req1_valid = 1'b1;
      req1_data  = 8'h78;
      wait_ready(1'b0, 40, n, got);
      check("to_next_served", 32'(req1_ready), 32'd1);
      check("to_next_data", 32'(tx_data), 32'h78);
      req1_valid = 1'b0;
      serve(1'b0, 1'b1, 8'h78, 3);
      check("to_err_sticky", 32'(timeout_err), 32'd1);
      check("to_ready_pulses", 32'(ready_cnt - rc), 32'd2);
      idle_wait(Gap + 4);

      // Reset during WAIT_DONE: outputs clear at once, no stray tx_start afterwards.
      req1_valid = 1'b1;
      req1_data  = 8'h5A;
      wait_ready(1'b0, 5, n, got);
      req1_valid = 1'b0;
      idle_wait(3);
      tx_busy = 1'b1;
      idle_wait(5);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx_start", 32'(tx_start), 32'd0);
      check("mid_rst_ready", 32'(req0_ready | req1_ready), 32'd0);
      check("mid_rst_tx_data", 32'(tx_data), 32'h00);
      check("mid_rst_grant_id", 32'(grant_id), 32'd0);
      check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
      idle_wait(2);
      sc = start_cnt;
      rst_n = 1'b1;
      idle_wait(5);
      tx_busy = 1'b0;
      idle_wait(30);
      check("mid_rst_no_start", 32'(start_cnt - sc), 32'd0);

      // Vector table; the first entry shows the pointer is back at 1 after reset.
      foreach (vecs[i]) begin
         sc = start_cnt;
         req0_valid = vecs[i].r0v;
         req0_data  = vecs[i].r0d;
         req1_valid = vecs[i].r1v;
         req1_data  = vecs[i].r1d;
         wait_ready(1'b0, 3, n, got);
         check("vec_granted", 32'(got), 32'(vecs[i].exp_any));
         if (vecs[i].exp_any) begin
            check("vec_latency", 32'(n), 32'd1);
            check("vec_ready0", 32'(req0_ready), 32'(!vecs[i].exp_gid));
            check("vec_ready1", 32'(req1_ready), 32'(vecs[i].exp_gid));
            check("vec_grant_id", 32'(grant_id), 32'(vecs[i].exp_gid));
            check("vec_tx_data", 32'(tx_data), 32'(vecs[i].exp_data));
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            serve(1'b0, vecs[i].exp_gid, vecs[i].exp_data, 4);
            check("vec_start_count", 32'(start_cnt - sc), 32'(NumBytes));
         end else begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            idle_wait(2);
            check("vec_no_start", 32'(start_cnt - sc), 32'd0);
         end
         idle_wait(Gap + 2);
      end

      // Zero gap: back-to-back requests from requester 0.
      s_req0_valid = 1'b1;
      s_req0_data  = 8'h10;
      wait_ready(1'b1, 5, n, got);
      check("nogap_first_grant", 32'(s_ready0), 32'd1);
      s_req0_data = 8'h20;
      serve(1'b1, 1'b0, 8'h10, 4);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!s_tx_start && n < 10);
      // Edge 1 samples busy low, edge 2 grants, edge 3 raises tx_start.
      check("nogap_restart", 32'(n), 32'd3);
      check("nogap_data", 32'(s_tx_data), 32'h20);
      s_req0_valid = 1'b0;

`ifdef UART_SCHED_CRLF_EN
      // CR LF suffix under requester 1 while requester 0 waits.
      idle_wait(Gap + 4);
      req1_valid = 1'b1;
      req1_data  = 8'h55;
      wait_ready(1'b0, 5, n, got);
      check("crlf_ready1", 32'(req1_ready), 32'd1);
      rc = ready_cnt;
      req1_valid = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 8'h66;
      serve(1'b0, 1'b1, 8'h55, 3);
      check("crlf_no_early_grant", 32'(ready_cnt - rc), 32'd1);
      wait_ready(1'b0, 40, n, got);
      check("crlf_req0_after", 32'(req0_ready), 32'd1);
      check("crlf_req0_data", 32'(tx_data), 32'h66);
      req0_valid = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
